sap_mem_arbiter: RTL and testbench

SAP_MEM_ARBITER -- requirements
Module: sap_mem_arbiter

---
 rtl/sap_mem_arbiter_if.sv | 37 +++
 rtl/sap_mem_arbiter.sv | 70 +++++++
 tb/tb_sap_mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sap_mem_arbiter_if.sv
// sap_mem_arbiter_if: CPU/loader request ports and single-port RAM bus for sap_mem_arbiter
interface sap_mem_arbiter_if #(parameter int ADDR_W = 4);
  logic              halt;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [7:0]        cpu_rdata;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [7:0]        ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [7:0]        ldr_rdata;
  logic              ldr_err;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport slave (
    input  halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    output mem_we, mem_addr, mem_wdata
  );
  modport master (
    output halt, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata, ldr_err,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sap_mem_arbiter.sv
// sap_mem_arbiter: CPU/loader RAM arbiter; define SAP_ARB_WRPROTECT_EN to block loader writes while running
module sap_mem_arbiter #(
  parameter int ADDR_W = 4
) (
  input logic              clk,
  input logic              reset,
  sap_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CPU_ACC, LDR_ACC} state_e;
  state_e            state_q, state_d;
  logic              last_ldr_q, last_ldr_d;
  logic              rd_v_q, rd_v_d;
  logic              rd_ldr_q, rd_ldr_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        ldr_rdata_q, ldr_rdata_d;
  logic              cpu_el, ldr_el, ldr_wins, wp;
  logic [ADDR_W-1:0] mem_addr;
`ifdef SAP_ARB_WRPROTECT_EN
  assign wp = state_q == LDR_ACC && bus.ldr_we && !bus.halt;
`else
  assign wp = 1'b0;
`endif
  always_comb begin
    cpu_el       = bus.cpu_req && state_q != CPU_ACC;
    ldr_el       = bus.ldr_req && state_q != LDR_ACC;
    ldr_wins     = ldr_el && (!cpu_el || bus.halt || !last_ldr_q);
    state_d      = ldr_wins ? LDR_ACC : cpu_el ? CPU_ACC : IDLE;
    last_ldr_d   = state_d == IDLE ? last_ldr_q : state_d == LDR_ACC;
    rd_v_d       = (state_q == CPU_ACC && !bus.cpu_we) || (state_q == LDR_ACC && !bus.ldr_we);
    rd_ldr_d     = state_q == LDR_ACC;
    cpu_rvalid_d = rd_v_q && !rd_ldr_q;
    ldr_rvalid_d = rd_v_q && rd_ldr_q;
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
    ldr_rdata_d  = ldr_rvalid_d ? bus.mem_rdata : ldr_rdata_q;
    mem_addr     = state_q == CPU_ACC ? bus.cpu_addr : state_q == LDR_ACC ? bus.ldr_addr : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_ldr_q   <= 1'b1;
      rd_v_q       <= 1'b0;
      rd_ldr_q     <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_ldr_q   <= last_ldr_d;
      rd_v_q       <= rd_v_d;
      rd_ldr_q     <= rd_ldr_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end
  assign bus.cpu_gnt    = state_q == CPU_ACC;
  assign bus.ldr_gnt    = state_q == LDR_ACC;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.ldr_err    = wp;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_we     = state_q == CPU_ACC ? bus.cpu_we : state_q == LDR_ACC ? bus.ldr_we && !wp : 1'b0;
  assign bus.mem_wdata  = state_q == CPU_ACC ? bus.cpu_wdata : state_q == LDR_ACC ? bus.ldr_wdata : 8'h00;
endmodule

// File: tb/tb_sap_mem_arbiter.sv
// tb_sap_mem_arbiter: scoreboard bench with a synchronous RAM model for sap_mem_arbiter
module tb_sap_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] cpu_q[$];
  logic [7:0] ldr_q[$];
  logic [7:0] ram [16] = '{8'h5A, 8'h11, 8'h22, 8'h2A, 8'h44, 8'h55, 8'h66, 8'h77,
                           8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
  sap_mem_arbiter_if #(.ADDR_W(4)) bus();
  sap_mem_arbiter #(.ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic cpu_set(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
    bus.cpu_req = req;
    bus.cpu_we = we;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
  endtask
  task automatic ldr_set(input logic req, input logic we, input logic [3:0] a, input logic [7:0] d);
    bus.ldr_req = req;
    bus.ldr_we = we;
    bus.ldr_addr = a;
    bus.ldr_wdata = d;
  endtask
  task automatic idle(input int n);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    repeat (n) step();
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 64'({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid, bus.cpu_rdata,
                  bus.ldr_rdata, bus.ldr_err, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_excl", 64'(bus.cpu_gnt & bus.ldr_gnt), 0);
      chk("rv_excl", 64'(bus.cpu_rvalid & bus.ldr_rvalid), 0);
      if (bus.cpu_rvalid) begin
        if (cpu_q.size() == 0) chk("cpu_rv_unexp", 1, 0);
        else chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(cpu_q.pop_front()));
      end
      if (bus.ldr_rvalid) begin
        if (ldr_q.size() == 0) chk("ldr_rv_unexp", 1, 0);
        else chk("ldr_rdata", 64'(bus.ldr_rdata), 64'(ldr_q.pop_front()));
      end
    end
  end
  initial begin
    bus.halt = 1'b0;
    cpu_set(0, 0, 0, 0);
    ldr_set(0, 0, 0, 0);
    repeat (3) step();
    chk_zero("rst_vals");
    reset = 1'b0;
    mon_en = 1'b1;
    cpu_set(1, 0, 4'h3, 8'h00);
    cpu_q.push_back(8'h2A);
    step();
    chk("t1_gnt", 64'(bus.cpu_gnt), 1);
    chk("t1_addr", 64'(bus.mem_addr), 3);
    chk("t1_we", 64'(bus.mem_we), 0);
    bus.cpu_req = 1'b0;
    step();
    chk("t1_rv_early", 64'(bus.cpu_rvalid), 0);
    step();
    chk("t1_rv", 64'(bus.cpu_rvalid), 1);
    step();
    chk("t1_rv_pulse", 64'(bus.cpu_rvalid), 0);
    chk("t1_rdata_hold", 64'(bus.cpu_rdata), 64'h2A);
    idle(2);
    bus.halt = 1'b1;
    ldr_set(1, 1, 4'h5, 8'hF0);
    cpu_set(1, 0, 4'h5, 8'h00);
    cpu_q.push_back(8'hF0);
    step();
    chk("t2_lgnt", 64'(bus.ldr_gnt), 1);
    chk("t2_cgnt0", 64'(bus.cpu_gnt), 0);
    chk("t2_we", 64'(bus.mem_we), 1);
    chk("t2_wdata", 64'(bus.mem_wdata), 64'hF0);
    chk("t2_addr", 64'(bus.mem_addr), 5);
    chk("t2_err", 64'(bus.ldr_err), 0);
    bus.ldr_req = 1'b0;
    step();
    chk("t2_cgnt", 64'(bus.cpu_gnt), 1);
    chk("t2_lgnt0", 64'(bus.ldr_gnt), 0);
    bus.cpu_req = 1'b0;
    step();
    chk("t2_wr_no_rv", 64'(bus.ldr_rvalid), 0);
    idle(3);
    bus.halt = 1'b0;
    reset = 1'b1;
    step();
    chk_zero("rst_mid");
    reset = 1'b0;
    cpu_set(1, 0, 4'h3, 8'h00);
    ldr_set(1, 0, 4'h5, 8'h00);
    repeat (4) begin
      cpu_q.push_back(8'h2A);
      ldr_q.push_back(8'hF0);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("t3_cgnt", 64'(bus.cpu_gnt), 64'(i % 2));
      chk("t3_lgnt", 64'(bus.ldr_gnt), 64'(!(i % 2)));
    end
    idle(4);
    cpu_set(1, 0, 4'h3, 8'h00);
    repeat (3) cpu_q.push_back(8'h2A);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("t4_cgnt", 64'(bus.cpu_gnt), 64'(i % 2));
      if (i == 5) bus.cpu_req = 1'b0;
    end
    idle(3);
    cpu_set(1, 0, 4'h5, 8'h00);
    step();
    chk("t5_gnt", 64'(bus.cpu_gnt), 1);
    bus.cpu_req = 1'b0;
    reset = 1'b1;
    step();
    chk_zero("t5_rst");
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("t5_no_rv", 64'(bus.cpu_rvalid), 0);
    end
    ldr_set(1, 1, 4'h0, 8'h77);
    step();
    chk("t6_gnt", 64'(bus.ldr_gnt), 1);
`ifdef SAP_ARB_WRPROTECT_EN
    chk("t6_we", 64'(bus.mem_we), 0);
    chk("t6_err", 64'(bus.ldr_err), 1);
    ldr_q.push_back(8'h5A);
`else
    chk("t6_we", 64'(bus.mem_we), 1);
    chk("t6_err", 64'(bus.ldr_err), 0);
    ldr_q.push_back(8'h77);
`endif
    bus.ldr_req = 1'b0;
    step();
    chk("t6_err_pulse", 64'(bus.ldr_err), 0);
    ldr_set(1, 0, 4'h0, 8'h00);
    step();
    chk("t6_rd_gnt", 64'(bus.ldr_gnt), 1);
    idle(4);
    bus.halt = 1'b1;
    ldr_set(1, 1, 4'h0, 8'h99);
    step();
    chk("t7_we", 64'(bus.mem_we), 1);
    chk("t7_err", 64'(bus.ldr_err), 0);
    bus.ldr_req = 1'b0;
    step();
    ldr_set(1, 0, 4'h0, 8'h00);
    ldr_q.push_back(8'h99);
    step();
    chk("t7_rd_gnt", 64'(bus.ldr_gnt), 1);
    idle(4);
    chk("cpu_q_empty", 64'(cpu_q.size()), 0);
    chk("ldr_q_empty", 64'(ldr_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
